// File: rtl/booths_div.sv
// rtl/booths_div.sv - sequential signed restoring divider with fixed N+1 clock latency
module booths_div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dvd,
    input  logic [N-1:0] dvs,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_fix;

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_prem;      // partial remainder; the trial-subtract carry bit lives in w_shift
    logic [N-1:0]  r_qreg;
    logic [N-1:0]  r_dvs_mag;
    logic [N-1:0]  r_dvd;
    logic          r_sign_q;
    logic          r_sign_r;
    logic          r_is_dbz;
    logic          r_is_ovf;

    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic [N:0]    w_shift;
    logic [N:0]    w_diff;
    logic [N-1:0]  w_quo_fix;
    logic [N-1:0]  w_rem_fix;

    assign w_dvd_mag = dvd[N-1] ? (~dvd + 1'b1) : dvd;
    assign w_dvs_mag = dvs[N-1] ? (~dvs + 1'b1) : dvs;

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    assign w_shift = {r_prem, r_qreg[N-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs_mag};

    assign w_quo_fix = r_sign_q ? (~r_qreg + 1'b1) : r_qreg;
    assign w_rem_fix = r_sign_r ? (~r_prem + 1'b1) : r_prem;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ITER leaves on the edge where the counter reaches zero.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_fix    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_ITER;
                end
            end
            S_ITER: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_fix  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_prem    <= '0;
            r_qreg    <= '0;
            r_dvs_mag <= '0;
            r_dvd     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_is_dbz  <= 1'b0;
            r_is_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= CW'(N);
            r_prem    <= '0;
            r_qreg    <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_dvd     <= dvd;
            r_sign_q  <= dvd[N-1] ^ dvs[N-1];
            r_sign_r  <= dvd[N-1];
            r_is_dbz  <= (dvs == '0);
            r_is_ovf  <= (dvd == MOST_NEG) && (&dvs);
        end else if (r_state == S_ITER) begin
            r_cnt  <= r_cnt - 1'b1;
            r_prem <= w_diff[N] ? w_shift[N-1:0] : w_diff[N-1:0];
            r_qreg <= {r_qreg[N-2:0], ~w_diff[N]};
        end
    end

    // Result registers, flags and handshake; results only move at the FIX edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo  <= '0;
            rem  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= w_fix;
            if (w_accept) begin
                busy <= 1'b1;
            end else if (w_fix) begin
                busy <= 1'b0;
            end
            if (w_fix) begin
                dbz <= r_is_dbz;
                ovf <= r_is_ovf && !r_is_dbz;
                if (r_is_dbz) begin
                    quo <= '1;
                    rem <= r_dvd;
                end else if (r_is_ovf) begin
                    quo <= MOST_NEG;
                    rem <= '0;
                end else begin
                    quo <= w_quo_fix;
                    rem <= w_rem_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_booths_div.sv
// tb/tb_booths_div.sv - self-checking bench for booths_div (N=4)
module tb_booths_div;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic         busy;
    logic         done;
    logic         dbz;
    logic         ovf;

    int n_checks;
    int n_errors;

    booths_div #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .dvd  (dvd),
        .dvs  (dvs),
        .quo  (quo),
        .rem  (rem),
        .busy (busy),
        .done (done),
        .dbz  (dbz),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        logic       o;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain signed integer division plus the two forced cases.
    function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int q;
        int r;
        logic [3:0] qq;
        logic [3:0] rr;
        logic z;
        logic o;
        ia = $signed(a);
        ib = $signed(b);
        if (ib == 0) begin
            q = -1; r = ia; z = 1'b1; o = 1'b0;
        end else if (ia == -8 && ib == -1) begin
            q = -8; r = 0; z = 1'b0; o = 1'b1;
        end else begin
            q = ia / ib; r = ia % ib; z = 1'b0; o = 1'b0;
        end
        qq = q[3:0];
        rr = r[3:0];
        return {qq, rr, z, o};
    endfunction

    // Called at a negedge with the block idle or in its done cycle; returns at the
    // negedge of the done cycle. lat counts clocks from the accept edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold, output int lat);
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        if (!hold) start = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_op(input string nm, input logic [3:0] a, input logic [3:0] b, input int lat);
        chk({nm, "_lat"}, lat, N + 1);
        chk({nm, "_res"}, {22'd0, quo, rem, dbz, ovf}, {22'd0, model(a, b)});
        chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [3:0] a;
        logic [3:0] b;

        n_checks = 0;
        n_errors = 0;
        rst   = 1'b0;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;

        tbl[0] = '{4'd7,  4'd2,  4'b0011, 4'b0001, 1'b0, 1'b0};
        tbl[1] = '{4'b1001, 4'd2,  4'b1101, 4'b1111, 1'b0, 1'b0};
        tbl[2] = '{4'd7,  4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0};
        tbl[3] = '{4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0, 1'b0};
        tbl[4] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1};
        tbl[5] = '{4'd5,  4'd0,  4'b1111, 4'b0101, 1'b1, 1'b0};
        tbl[6] = '{4'b1000, 4'd1,  4'b1000, 4'b0000, 1'b0, 1'b0};
        tbl[7] = '{4'd6,  4'd4,  4'b0001, 4'b0010, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {18'd0, quo, rem, busy, done, dbz, ovf}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors with bench-written expected values.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, 1'b0, lat);
            chk($sformatf("tbl%0d_lat", i), lat, N + 1);
            chk($sformatf("tbl%0d_res", i), {22'd0, quo, rem, dbz, ovf},
                {22'd0, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].o});
            @(negedge clk);
        end

        // start pulsed while busy is ignored.
        dvd = 4'd7; dvs = 4'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        start = 1'b0;
        chk("busy_after_accept", {30'd0, busy, done}, 32'd2);
        @(negedge clk);
        lat++;
        dvd = 4'd3; dvs = 4'd1; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_lat", lat, N + 1);
        chk("ignore_res", {22'd0, quo, rem, dbz, ovf}, {22'd0, 4'b0011, 4'b0001, 1'b0, 1'b0});
        @(negedge clk);
        chk("ignore_no_restart", {31'd0, busy}, 32'd0);

        // start held high: next op is accepted in the done cycle.
        run_op(4'd7, 4'd2, 1'b1, lat);
        chk_op("b2b_first", 4'd7, 4'd2, lat);
        run_op(4'b1001, 4'd3, 1'b1, lat);
        chk_op("b2b_second", 4'b1001, 4'd3, lat);
        run_op(4'd5, 4'b1101, 1'b0, lat);
        chk_op("b2b_third", 4'd5, 4'b1101, lat);
        @(negedge clk);

        // Asynchronous reset between edges mid-ITER.
        dvd = 4'd7; dvs = 4'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", {18'd0, quo, rem, busy, done, dbz, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("no_done_after_reset", ndone, 0);
        run_op(4'd6, 4'd4, 1'b0, lat);
        chk("post_reset_lat", lat, N + 1);
        chk("post_reset_res", {22'd0, quo, rem, dbz, ovf}, {22'd0, 4'b0001, 4'b0010, 1'b0, 1'b0});
        @(negedge clk);

        // Exhaustive back-to-back sweep against the reference.
        for (int i = 0; i < 256; i++) begin
            a = i[7:4];
            b = i[3:0];
            run_op(a, b, (i != 255), lat);
            chk($sformatf("sweep_%0d_%0d", $signed(a), $signed(b)), {31'd0, 1'b0}, {31'd0, 1'b0} | 0);
            n_checks--;
            chk_op($sformatf("sweep_%0d_%0d", $signed(a), $signed(b)), a, b, lat);
        end
        start = 1'b0;
        @(negedge clk);

        // Random operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            run_op(a, b, 1'b0, lat);
            chk_op($sformatf("rand%0d", i), a, b, lat);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
